// File: rtl/operation_msub_bw16_inc3.sv
// Sequential truncated multiply-subtract: RES = IN0 - IN1*IN2, clamped at 0.
// Shift-add multiply one bit per cycle, then a single compare/subtract cycle.
module operation_msub_bw16_inc3 #(
    parameter int BW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    input  logic [BW-1:0] IN0,
    input  logic [BW-1:0] IN1,
    input  logic [BW-1:0] IN2
);

    localparam int KW = $clog2(BW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUB  = 2'd2
    } state_t;

    state_t            state_q;
    logic              st_old_q;
    logic              rd_q;
    logic [BW-1:0]     res_q;
    logic [BW-1:0]     a_q;
    logic [BW-1:0]     mp_q;
    logic [2*BW-1:0]   mc_q;
    logic [2*BW-1:0]   p_q;
    logic [KW-1:0]     k_q;

    logic              start_d;
    logic              last_bit_d;
    logic [2*BW-1:0]   p_d;

    // Full-width compare so products beyond BW bits still saturate to zero.
    function automatic logic [BW-1:0] sat_diff(input logic [BW-1:0] a,
                                               input logic [2*BW-1:0] p);
        if (p >= {{BW{1'b0}}, a})
            sat_diff = '0;
        else
            sat_diff = a - p[BW-1:0];
    endfunction

    assign start_d    = ST && !st_old_q && (state_q == IDLE);
    assign last_bit_d = (k_q == KW'(BW-1));
    assign p_d        = mp_q[0] ? (p_q + mc_q) : p_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            st_old_q <= 1'b0;
            rd_q     <= 1'b1;
            res_q    <= '0;
            a_q      <= '0;
            mp_q     <= '0;
            mc_q     <= '0;
            p_q      <= '0;
            k_q      <= '0;
        end else begin
            st_old_q <= ST;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        a_q     <= IN0;
                        mc_q    <= {{BW{1'b0}}, IN1};
                        mp_q    <= IN2;
                        p_q     <= '0;
                        k_q     <= '0;
                        rd_q    <= 1'b0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    p_q  <= p_d;
                    mc_q <= mc_q << 1;
                    mp_q <= mp_q >> 1;
                    k_q  <= k_q + 1'b1;
                    if (last_bit_d)
                        state_q <= SUB;
                end
                SUB: begin
                    res_q   <= sat_diff(a_q, p_q);
                    rd_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b1;
                end
            endcase
        end
    end

    assign RD  = rd_q;
    assign RES = res_q;

endmodule

// File: tb/tb_operation_msub_bw16_inc3.sv
// Directed bench for operation_msub_bw16_inc3 with a queue scoreboard of expected results.
module tb_operation_msub_bw16_inc3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ST  = 1'b0;
    logic [15:0] IN0 = '0;
    logic [15:0] IN1 = '0;
    logic [15:0] IN2 = '0;
    logic        RD;
    logic [15:0] RES;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    operation_msub_bw16_inc3 #(.BW(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .ST (ST),
        .RD (RD),
        .RES(RES),
        .IN0(IN0),
        .IN1(IN1),
        .IN2(IN2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] n);
        logic [31:0] prod;
        prod = {16'd0, y} * {16'd0, n};
        if (prod >= {16'd0, x})
            return 16'd0;
        return x - prod[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: plain; 1: scramble inputs after E0; 2: ST toggles while busy
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input int mode, output logic [15:0] res);
        int          lat;
        logic [15:0] e;
        @(negedge CLK);
        IN0 = a; IN1 = b; IN2 = c; ST = 1'b1;
        exp_q.push_back(model(a, b, c));
        @(posedge CLK); #1;
        chk({tag, "_rd_low"}, 32'(RD), 32'd0);
        if (mode == 1) begin
            IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK); #1;
            if (mode == 2) begin
                if (i == 4) ST = 1'b0;
                if (i == 5) ST = 1'b1;
                if (i == 6) ST = 1'b0;
            end
            if (RD) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd17);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "_res"}, 32'(RES), 32'(e));
        res = RES;
        for (int j = 0; j < 2; j++) begin
            @(posedge CLK); #1;
            chk({tag, "_rd_hold"}, 32'(RD), 32'd1);
        end
        @(negedge CLK);
        ST = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        int          cnt;

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rd", 32'(RD), 32'd1);
        chk("rst_res", 32'(RES), 32'd0);
        @(negedge CLK); ST = 1'b1; IN0 = 16'd100; IN1 = 16'd7; IN2 = 16'd3;
        @(posedge CLK); #1;
        chk("rst_st_rd", 32'(RD), 32'd1);
        @(negedge CLK); ST = 1'b0;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_rd", 32'(RD), 32'd1);
        chk("post_rst_res", 32'(RES), 32'd0);

        run_op("basic",   16'd100,   16'd7,     16'd3,     0, r);
        chk("basic_val", 32'(r), 32'd79);
        run_op("sat_lt",  16'd20,    16'd7,     16'd3,     0, r);
        run_op("sat_max", 16'hFFFF,  16'hFFFF,  16'hFFFF,  0, r);
        run_op("sat_eq",  16'd21,    16'd7,     16'd3,     0, r);
        run_op("zero_mp", 16'h1234,  16'd5,     16'd0,     0, r);
        run_op("stable",  16'd1000,  16'd3,     16'd9,     1, r);
        run_op("busy",    16'd500,   16'd4,     16'd5,     2, r);
        run_op("big",     16'hF000,  16'd255,   16'd200,   0, r);

        // Reset in the middle of a multiply abandons it.
        @(negedge CLK);
        IN0 = 16'd999; IN1 = 16'd2; IN2 = 16'd3; ST = 1'b1;
        @(posedge CLK);
        for (int i = 1; i <= 8; i++) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("midrst_rd", 32'(RD), 32'd1);
        chk("midrst_res", 32'(RES), 32'd0);
        @(negedge CLK); RST = 1'b0; ST = 1'b0;
        run_op("post_midrst", 16'd300, 16'd12, 16'd11, 0, r);

        // Minimization composition: smallest CNT with f(100,7,CNT)=0.
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            run_op("minz", 16'd100, 16'd7, 16'(n), 0, r);
            cnt = n;
            if (r == 16'd0) break;
        end
        chk("minz_cnt", 32'(cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
